// File: rtl/board_draw_sequencer_pkg.sv
// rtl/board_draw_sequencer_pkg.sv - shared constants and types for the board draw sequencer
package board_draw_sequencer_pkg;

    localparam int          GRID_CELLS             = 16;
    localparam logic [3:0]  LAST_CELL              = 4'd15;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 32768;
    localparam int          DEFAULT_TIMEOUT_W      = 16;

    typedef enum logic [1:0] {
        MODE_FULL = 2'd0,
        MODE_MOVE = 2'd1,
        MODE_LOAD = 2'd2
    } mode_e;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH      = 4'd1,
        ST_ISSUE      = 4'd2,
        ST_WAIT       = 4'd3,
        ST_NEXT       = 4'd4,
        ST_LOAD_ISSUE = 4'd5,
        ST_LOAD_WAIT  = 4'd6,
        ST_FINISH     = 4'd7,
        ST_ERROR      = 4'd8
    } state_e;

    // States in which a request is still in flight; FINISH and ERROR drop busy.
    function automatic logic state_is_busy(input state_e s);
        case (s)
            ST_FETCH, ST_ISSUE, ST_WAIT, ST_NEXT,
            ST_LOAD_ISSUE, ST_LOAD_WAIT: state_is_busy = 1'b1;
            default:                     state_is_busy = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/board_draw_sequencer_done_wait_timer.sv
// rtl/board_draw_sequencer_done_wait_timer.sv - saturating wait counter with expiry flag
module done_wait_timer #(
    parameter int LIMIT = 32768,
    parameter int W     = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST_COUNT = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX_COUNT  = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Count wait cycles; clear wins over enable, and the count sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != MAX_COUNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expired during the last permitted wait cycle, so the FSM leaves after LIMIT cycles.
    assign expired = en && (count_q >= LAST_COUNT);

endmodule

// File: rtl/board_draw_sequencer.sv
// rtl/board_draw_sequencer.sv - turns redraw requests into tile display engine handshakes
module board_draw_sequencer
    import board_draw_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_W      = DEFAULT_TIMEOUT_W
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_full,
    input  logic       start_move,
    input  logic [3:0] cell_a,
    input  logic [3:0] cell_b,
    input  logic       load_screen,
    input  logic [2:0] screen_sel,
    input  logic [2:0] tile_sprite,
    output logic [3:0] board_rd_addr,
    input  logic [3:0] board_rd_id,
    output logic [3:0] address,
    output logic [3:0] ID,
    output logic [2:0] sprite_sel,
    output logic       plot,
    output logic       load_sprite,
    input  logic       disp_done,
    output logic       busy,
    output logic       finished,
    output logic       error
);

    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    logic [3:0] cell_q, cell_d;
    logic [3:0] cell_a_q, cell_a_d;
    logic [3:0] cell_b_q, cell_b_d;
    logic [2:0] tile_sprite_q, tile_sprite_d;
    logic [3:0] address_q, address_d;
    logic [3:0] id_q, id_d;
    logic [2:0] sprite_sel_q, sprite_sel_d;
    logic       plot_q, plot_d;
    logic       load_sprite_q, load_sprite_d;
    logic       busy_q, busy_d;
    logic       finished_q, finished_d;
    logic       error_q, error_d;

    logic       timer_clr;
    logic       timer_en;
    logic       timer_expired;

    done_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TIMEOUT_W)
    ) u_done_wait_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Next-state and registered-output decode; pulses are set on the edge entering their state.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cell_d        = cell_q;
        cell_a_d      = cell_a_q;
        cell_b_d      = cell_b_q;
        tile_sprite_d = tile_sprite_q;
        address_d     = address_q;
        id_d          = id_q;
        sprite_sel_d  = sprite_sel_q;
        plot_d        = 1'b0;
        load_sprite_d = 1'b0;
        finished_d    = 1'b0;
        error_d       = error_q;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_screen || start_full || start_move) begin
                    cell_a_d      = cell_a;
                    cell_b_d      = cell_b;
                    tile_sprite_d = tile_sprite;
                    error_d       = 1'b0;
                    if (load_screen) begin
                        // Screen select is presented together with the load pulse.
                        mode_d        = MODE_LOAD;
                        sprite_sel_d  = screen_sel;
                        load_sprite_d = 1'b1;
                        state_d       = ST_LOAD_ISSUE;
                    end else if (start_full) begin
                        mode_d  = MODE_FULL;
                        cell_d  = 4'd0;
                        state_d = ST_FETCH;
                    end else begin
                        mode_d  = MODE_MOVE;
                        cell_d  = cell_a;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                // board_rd_addr is the cell counter, so board_rd_id is valid now.
                address_d    = cell_q;
                id_d         = board_rd_id;
                sprite_sel_d = tile_sprite_q;
                plot_d       = 1'b1;
                state_d      = ST_ISSUE;
            end

            ST_ISSUE: begin
                timer_clr = 1'b1;
                state_d   = ST_WAIT;
            end

            ST_WAIT: begin
                timer_en = 1'b1;
                if (disp_done) begin
                    state_d = ST_NEXT;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end
            end

            ST_NEXT: begin
                if ((mode_q == MODE_FULL) && (cell_q != LAST_CELL)) begin
                    cell_d  = 4'(cell_q + 4'd1);
                    state_d = ST_FETCH;
                end else if ((mode_q == MODE_MOVE) && (cell_q == cell_a_q) &&
                             (cell_b_q != cell_a_q)) begin
                    cell_d  = cell_b_q;
                    state_d = ST_FETCH;
                end else begin
                    finished_d = 1'b1;
                    state_d    = ST_FINISH;
                end
            end

            ST_LOAD_ISSUE: begin
                timer_clr = 1'b1;
                state_d   = ST_LOAD_WAIT;
            end

            ST_LOAD_WAIT: begin
                timer_en = 1'b1;
                if (disp_done) begin
                    finished_d = 1'b1;
                    state_d    = ST_FINISH;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            ST_ERROR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = state_is_busy(state_d);
    end

    // State, operand and output registers; reset returns everything to idle and zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_FULL;
            cell_q        <= '0;
            cell_a_q      <= '0;
            cell_b_q      <= '0;
            tile_sprite_q <= '0;
            address_q     <= '0;
            id_q          <= '0;
            sprite_sel_q  <= '0;
            plot_q        <= 1'b0;
            load_sprite_q <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cell_q        <= cell_d;
            cell_a_q      <= cell_a_d;
            cell_b_q      <= cell_b_d;
            tile_sprite_q <= tile_sprite_d;
            address_q     <= address_d;
            id_q          <= id_d;
            sprite_sel_q  <= sprite_sel_d;
            plot_q        <= plot_d;
            load_sprite_q <= load_sprite_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
            error_q       <= error_d;
        end
    end

    assign board_rd_addr = cell_q;
    assign address       = address_q;
    assign ID            = id_q;
    assign sprite_sel    = sprite_sel_q;
    assign plot          = plot_q;
    assign load_sprite   = load_sprite_q;
    assign busy          = busy_q;
    assign finished      = finished_q;
    assign error         = error_q;

endmodule

// File: tb/tb_board_draw_sequencer.sv
// tb/tb_board_draw_sequencer.sv - randomized self-checking bench for board_draw_sequencer
module tb_board_draw_sequencer;

    localparam int T = 32768;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start_full = 1'b0;
    logic       start_move = 1'b0;
    logic [3:0] cell_a = '0;
    logic [3:0] cell_b = '0;
    logic       load_screen = 1'b0;
    logic [2:0] screen_sel = '0;
    logic [2:0] tile_sprite = '0;
    logic [3:0] board_rd_addr;
    logic [3:0] board_rd_id;
    logic [3:0] address;
    logic [3:0] ID;
    logic [2:0] sprite_sel;
    logic       plot;
    logic       load_sprite;
    logic       disp_done;
    logic       busy;
    logic       finished;
    logic       error;

    logic [3:0] board [16];
    assign board_rd_id = board[board_rd_addr];

    always #10 clk = ~clk;

    board_draw_sequencer #(
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_W      (16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start_full    (start_full),
        .start_move    (start_move),
        .cell_a        (cell_a),
        .cell_b        (cell_b),
        .load_screen   (load_screen),
        .screen_sel    (screen_sel),
        .tile_sprite   (tile_sprite),
        .board_rd_addr (board_rd_addr),
        .board_rd_id   (board_rd_id),
        .address       (address),
        .ID            (ID),
        .sprite_sel    (sprite_sel),
        .plot          (plot),
        .load_sprite   (load_sprite),
        .disp_done     (disp_done),
        .busy          (busy),
        .finished      (finished),
        .error         (error)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observed engine requests: {address, ID, sprite_sel} per plot, sprite_sel per load.
    logic [10:0] plot_log [$];
    logic [2:0]  load_log [$];
    int          fin_cnt = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (plot)        plot_log.push_back({address, ID, sprite_sel});
            if (load_sprite) load_log.push_back(sprite_sel);
            if (finished)    fin_cnt++;
        end
    end

    // Engine model: busy for eng_lat cycles after a request, then a one-cycle done.
    logic        eng_done = 1'b0;
    logic        spur_done = 1'b0;
    bit          eng_busy = 1'b0;
    bit          eng_en = 1'b1;
    int          eng_cnt = 0;
    int          eng_lat = 4;
    int          done_cnt = 0;
    logic [10:0] hold_v = '0;
    assign disp_done = eng_done | spur_done;

    always @(negedge clk) begin
        eng_done = 1'b0;
        if (!resetn) begin
            eng_busy = 1'b0;
        end else if (eng_busy) begin
            chk("hold_stable", {21'd0, address, ID, sprite_sel}, {21'd0, hold_v});
            if (plot || load_sprite) chk("request_while_engine_busy", 1, 0);
            if (eng_cnt <= 1) begin
                eng_done = 1'b1;
                eng_busy = 1'b0;
                done_cnt++;
            end else begin
                eng_cnt--;
            end
        end else if ((plot || load_sprite) && eng_en) begin
            eng_busy = 1'b1;
            eng_cnt  = eng_lat;
            hold_v   = {address, ID, sprite_sel};
        end
    end

    task automatic randomize_board();
        for (int c = 0; c < 16; c++) board[c] = 4'($urandom_range(0, 15));
    endtask

    // Issue one request, wait for completion and compare against the expected tile list.
    task automatic do_req(input bit rl, input bit rf, input bit rm, input logic [3:0] a,
                          input logic [3:0] b, input logic [2:0] scr, input logic [2:0] spr,
                          input int lat, input bit poke);
        logic [10:0] exp_q [$];
        bit          is_load;
        bit          fin;
        bit          err;
        int          n;
        is_load = rl;
        if (rl) begin
            // screen load: no tiles
        end else if (rf) begin
            for (int c = 0; c < 16; c++) exp_q.push_back({4'(c), board[c], spr});
        end else begin
            exp_q.push_back({a, board[a], spr});
            if (b != a) exp_q.push_back({b, board[b], spr});
        end
        plot_log.delete();
        load_log.delete();
        fin_cnt = 0;
        eng_lat = lat;
        @(negedge clk);
        load_screen = rl; start_full = rf; start_move = rm;
        cell_a = a; cell_b = b; screen_sel = scr; tile_sprite = spr;
        @(negedge clk);
        load_screen = 0; start_full = 0; start_move = 0;
        cell_a = 4'($urandom); cell_b = 4'($urandom);
        screen_sel = 3'($urandom); tile_sprite = 3'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("error_cleared_on_accept", error, 0);
        fin = 0; err = 0; n = 0;
        while (!fin && !err && n < 20000) begin
            @(negedge clk);
            n++;
            start_move = (poke && n == 40);
            if (finished) fin = 1;
            else if (error) err = 1;
        end
        start_move = 0;
        chk("finished_seen", fin, 1);
        chk("plot_count", plot_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < plot_log.size(); i++)
            chk($sformatf("plot%0d", i), plot_log[i], exp_q[i]);
        chk("load_count", load_log.size(), is_load ? 1 : 0);
        if (is_load && load_log.size() > 0) chk("load_sel", load_log[0], scr);
        @(negedge clk);
        chk("busy_low_after", busy, 0);
        chk("finished_once", fin_cnt, 1);
        repeat (6) @(negedge clk);
        chk("no_extra_plot", plot_log.size() + load_log.size(), exp_q.size() + (is_load ? 1 : 0));
    endtask

    initial begin
        int n;
        int cnt;
        logic [2:0] r;
        logic [3:0] a;
        logic [3:0] b;

        randomize_board();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {plot, load_sprite, busy, finished, error, address, ID,
                              sprite_sel, board_rd_addr}, 0);
        resetn = 1;
        repeat (2) @(negedge clk);

        // Full redraw with board[c] = 15 - c, slow engine.
        for (int c = 0; c < 16; c++) board[c] = 4'(15 - c);
        do_req(0, 1, 0, 4'd0, 4'd0, 3'd0, 3'd5, 520, 1'b1);

        // Move redraws.
        randomize_board();
        board[5] = 4'd15; board[6] = 4'd9;
        do_req(0, 0, 1, 4'd5, 4'd6, 3'd0, 3'd3, 7, 1'b0);
        do_req(0, 0, 1, 4'd3, 4'd3, 3'd0, 3'd1, 3, 1'b0);

        // Load has priority over a simultaneous full redraw.
        do_req(1, 1, 0, 4'd0, 4'd0, 3'd2, 3'd4, 100, 1'b0);

        // Spurious done while idle.
        plot_log.delete(); fin_cnt = 0;
        @(negedge clk); spur_done = 1;
        @(negedge clk); spur_done = 0;
        repeat (4) @(negedge clk);
        chk("spurious_busy", busy, 0);
        chk("spurious_plot", plot_log.size(), 0);
        chk("spurious_finished", fin_cnt, 0);

        // Engine never answers: timeout.
        randomize_board();
        eng_en = 0; fin_cnt = 0;
        @(negedge clk); start_move = 1; cell_a = 4'd9; cell_b = 4'd9; tile_sprite = 3'd6;
        @(negedge clk); start_move = 0;
        n = 0;
        while (!plot && n < 10) begin @(negedge clk); n++; end
        chk("timeout_plot_seen", plot, 1);
        cnt = 0;
        while (!error && cnt < 40000) begin @(negedge clk); cnt++; end
        chk("timeout_cycles", cnt, T + 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_finished", fin_cnt, 0);
        @(negedge clk);
        chk("error_sticky", error, 1);
        eng_en = 1;
        do_req(0, 0, 1, 4'd2, 4'd7, 3'd0, 3'd2, 5, 1'b0);

        // Reset in the middle of a full redraw.
        randomize_board();
        eng_lat = 20; done_cnt = 0;
        @(negedge clk); start_full = 1; tile_sprite = 3'd7;
        @(negedge clk); start_full = 0;
        n = 0;
        while (done_cnt < 7 && n < 2000) begin @(negedge clk); n++; end
        chk("seven_tiles_done", done_cnt, 7);
        resetn = 0;
        @(negedge clk);
        chk("midreset_outputs", {plot, load_sprite, busy, finished, error, address, ID,
                                 sprite_sel, board_rd_addr}, 0);
        #5 resetn = 1;
        repeat (3) @(negedge clk);
        chk("midreset_idle", {busy, plot}, 0);
        do_req(0, 1, 0, 4'd0, 4'd0, 3'd0, 3'd3, 2, 1'b0);

        // Randomized requests with random priority collisions and engine latency.
        for (int it = 0; it < 12; it++) begin
            randomize_board();
            r = 3'($urandom_range(1, 7));
            a = 4'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom);
            do_req(r[2], r[1], r[0], a, b, 3'($urandom), 3'($urandom),
                   $urandom_range(1, 30), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
